// File: rtl/mul_sched_pkg.sv
// Shared types and defaults for the two-requester multiplier scheduler.
package mul_sched_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int LAT_DEF   = 10;
    localparam int DEPTH_DEF = 12;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    typedef struct packed {
        logic        id;
        logic [63:0] c;
    } rsp_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO; head entry is visible on dout
// whenever empty is low. Any DEPTH >= 1 is supported (pointers wrap explicitly).
module sync_fifo_fwft #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage has no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/wallace_mul_sched.sv
// Round-robin scheduler sharing one LAT-deep multiplier between two requesters,
// with a shadow {valid,id} pipeline and a credit-gated response FIFO.
module wallace_mul_sched
    import mul_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [WIDTH-1:0]           req0_a,
    input  logic [WIDTH-1:0]           req0_b,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [WIDTH-1:0]           req1_a,
    input  logic [WIDTH-1:0]           req1_b,
    output logic [WIDTH:0]             mul_a,
    output logic [WIDTH:0]             mul_b,
    input  logic [2*WIDTH:0]           mul_c,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_id,
    output logic [2*WIDTH-1:0]         rsp_c,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] inflight_q, inflight_d, fifo_count;
    req_id_t          prio_q, prio_d, grant;
    logic [WIDTH:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [LAT:0]     sh_valid_q, sh_id_q;
    rsp_entry_t       push_entry, head_entry;
    logic             pop, push, credit_ok, any_req, issue;
    logic             fifo_full, fifo_empty;
    logic             unused_mul_c_msb;

    assign pop       = rsp_valid && rsp_ready;
    assign credit_ok = (inflight_q - CNT_W'(pop)) < CNT_W'(DEPTH);
    assign any_req   = req0_valid || req1_valid;
    assign issue     = any_req && credit_ok && !rst;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant = prio_q;
        if (req0_valid && !req1_valid) grant = REQ0;
        else if (req1_valid && !req0_valid) grant = REQ1;

        req0_ready = issue && (grant == REQ0);
        req1_ready = issue && (grant == REQ1);

        prio_d  = prio_q;
        mul_a_d = '0;
        mul_b_d = '0;
        if (issue) begin
            prio_d  = (grant == REQ0) ? REQ1 : REQ0;
            mul_a_d = {1'b0, (grant == REQ0) ? req0_a : req1_a};
            mul_b_d = {1'b0, (grant == REQ0) ? req0_b : req1_b};
        end

        case ({issue, pop})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // Stage k holds the tag of the operands loaded k cycles ago; stage LAT lines up with mul_c.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q     <= REQ0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            inflight_q <= '0;
            sh_valid_q <= '0;
            sh_id_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            inflight_q <= inflight_d;
            sh_valid_q <= {sh_valid_q[LAT-1:0], issue};
            sh_id_q    <= {sh_id_q[LAT-1:0], logic'(grant)};
        end
    end

    assign mul_a            = mul_a_q;
    assign mul_b            = mul_b_q;
    assign inflight         = inflight_q;
    assign unused_mul_c_msb = mul_c[2*WIDTH];

    assign push          = sh_valid_q[LAT];
    assign push_entry.id = sh_id_q[LAT];
    assign push_entry.c  = 64'(mul_c[2*WIDTH-1:0]);

    sync_fifo_fwft #(
        .W     ($bits(rsp_entry_t)),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rsp_valid = !fifo_empty;
    assign rsp_id    = !fifo_empty && head_entry.id;
    assign rsp_c     = fifo_empty ? '0 : head_entry.c[2*WIDTH-1:0];

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst) push |-> !fifo_full);
    a_credit_bound:      assert property (@(posedge clk) disable iff (rst)
                                          (inflight_q <= CNT_W'(DEPTH)) && (fifo_count <= inflight_q));

endmodule

// File: tb/tb_wallace_mul_sched.sv
// Scoreboard bench for wallace_mul_sched with a LAT-deep behavioural multiplier.
module tb_wallace_mul_sched;
    import mul_sched_pkg::*;

    localparam int W     = WIDTH_DEF;
    localparam int LAT   = LAT_DEF;
    localparam int DEPTH = DEPTH_DEF;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk, rst;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]     req0_a, req0_b, req1_a, req1_b;
    logic [W:0]       mul_a, mul_b;
    logic [2*W:0]     mul_c;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [2*W-1:0]   rsp_c;
    logic [CNT_W-1:0] inflight;

    logic [2*W:0]     mpipe [LAT];
    logic [64:0]      exp_q [$];
    logic [64:0]      sb_e;
    logic [63:0]      exp0, exp1;
    int               n_checks = 0;
    int               n_fail   = 0;

    wallace_mul_sched #(.WIDTH(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_c      (mul_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_c      (rsp_c),
        .inflight   (inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier sharing rst; bit 2*W is driven high to prove it is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) mpipe[i] <= '0;
        end else begin
            mpipe[0] <= {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
            for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
        end
    end
    assign mul_c = {1'b1, mpipe[LAT-1][2*W-1:0]};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Issue tracker: records the expected response of every accepted request.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (req0_valid && req0_ready) exp_q.push_back({1'b0, exp0});
            if (req1_valid && req1_ready) exp_q.push_back({1'b1, exp1});
        end
    end

    // Response monitor: compares every popped head against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(1), 64'(0));
            end else begin
                sb_e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(sb_e[64]));
                check("rsp_c", rsp_c, sb_e[63:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] e);
        bit got = 1'b0;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; exp1 = e; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; exp0 = e; end
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (!got) check("issue_timeout", 64'(0), 64'(1));
    endtask

    task automatic stream0(input int n, input logic [31:0] b);
        int acc = 0;
        for (int cyc = 0; cyc < n * 4 + 20 && acc < n; cyc++) begin
            req0_valid = 1'b1;
            req0_a     = 32'(acc + 1);
            req0_b     = b;
            exp0       = 64'(acc + 1) * 64'(b);
            @(negedge clk);
            if (req0_ready) acc++;
            tick();
        end
        req0_valid = 1'b0;
        check("stream_accepts", 64'(acc), 64'(n));
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && inflight != '0; k++) tick();
        check("drain_inflight", 64'(inflight), 64'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  lat, idx0, idx1, acc;
        bit  exp_g, seen, got;

        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd7; req0_b = 32'd7;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        exp0 = '0; exp1 = '0;
        repeat (3) tick();
        check("rst_req0_ready", 64'(req0_ready), 64'(0));
        check("rst_req1_ready", 64'(req1_ready), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_id", 64'(rsp_id), 64'(0));
        check("rst_rsp_c", rsp_c, 64'(0));
        check("rst_inflight", 64'(inflight), 64'(0));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        req0_valid = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        tick();

        // Single issue: 3 x 5, response LAT+1 edges after the issue edge.
        req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd5; exp0 = 64'd15;
        @(negedge clk);
        check("single_ready", 64'(req0_ready), 64'(1));
        tick();
        req0_valid = 1'b0;
        check("single_inflight_1", 64'(inflight), 64'(1));
        check("single_mul_a", 64'(mul_a), 64'(3));
        check("single_mul_b", 64'(mul_b), 64'(5));
        lat = 0;
        for (int k = 1; k <= LAT + 5; k++) begin
            tick();
            if (rsp_valid) begin lat = k; break; end
        end
        check("single_latency", 64'(lat), 64'(LAT + 1));
        check("idle_mul_a", 64'(mul_a), 64'(0));
        tick();
        check("single_inflight_0", 64'(inflight), 64'(0));
        check("single_rsp_gone", 64'(rsp_valid), 64'(0));

        // Corner operands on requester 1 (also hands priority back to requester 0).
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        issue(1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0);
        drain();

        // Contention: grants must alternate 0,1,0,1 starting with requester 0.
        idx0 = 0; idx1 = 0; exp_g = 1'b0;
        for (int cyc = 0; cyc < 40 && (idx0 < 8 || idx1 < 8); cyc++) begin
            req0_valid = (idx0 < 8); req0_a = 32'(idx0 + 1); req0_b = 32'd2;
            exp0 = 64'(2 * (idx0 + 1));
            req1_valid = (idx1 < 8); req1_a = 32'(idx1 + 1); req1_b = 32'd3;
            exp1 = 64'(3 * (idx1 + 1));
            @(negedge clk);
            check("cont_grant", 64'({req1_ready, req0_ready}), exp_g ? 64'd2 : 64'd1);
            if (req0_ready) idx0++;
            if (req1_ready) idx1++;
            exp_g = ~exp_g;
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_done", 64'(idx0 + idx1), 64'(16));
        drain();

        // Backpressure: exactly DEPTH issues, then one pop frees one credit.
        rsp_ready = 1'b0; acc = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            req0_valid = 1'b1; req0_a = 32'(acc + 1); req0_b = 32'd7;
            exp0 = 64'(7 * (acc + 1));
            @(negedge clk);
            if (!req0_ready) break;
            acc++;
            tick();
        end
        check("bp_issue_count", 64'(acc), 64'(DEPTH));
        check("bp_ready_low", 64'(req0_ready), 64'(0));
        check("bp_inflight_full", 64'(inflight), 64'(DEPTH));
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rsp_valid", 64'(rsp_valid), 64'(1));
        check("bp_reissue_ready", 64'(req0_ready), 64'(1));
        tick();
        rsp_ready = 1'b0; req0_valid = 1'b0;
        check("bp_inflight_kept", 64'(inflight), 64'(DEPTH));
        rsp_ready = 1'b1;
        drain();

        // Sustained push+pop with a single buffered entry.
        rsp_ready = 1'b0;
        fork
            stream0(21, 32'd11);
            begin
                got = 1'b0;
                for (int k = 0; k < 60; k++) begin
                    tick();
                    if (rsp_valid) begin got = 1'b1; break; end
                end
                check("ff_first_valid", 64'(got), 64'(1));
                rsp_ready = 1'b1;
                check("ff_count", 64'(dut.u_rsp_fifo.count), 64'(1));
                for (int k = 1; k < 20; k++) begin
                    tick();
                    check("ff_count", 64'(dut.u_rsp_fifo.count), 64'(1));
                end
            end
        join
        drain();

        // Reset mid-flight: everything in the pipe is discarded.
        rsp_ready = 1'b1;
        stream0(4, 32'd13);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_inflight", 64'(inflight), 64'(0));
        check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        seen = 1'b0;
        repeat (2 * LAT) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("midrst_no_rsp", 64'(seen), 64'(0));
        check("midrst_inflight_idle", 64'(inflight), 64'(0));
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9; exp0 = 64'd81;
        @(negedge clk);
        check("midrst_ready_now", 64'(req0_ready), 64'(1));
        tick();
        req0_valid = 1'b0;
        drain();
        tick();
        check("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
